// File: rtl/sound_sequencer_if.sv
// Note-control bundle between the game logic, the sound sequencer and the tone oscillator.
// The game logic is the master and raises triggers; the sequencer is the slave and drives the notes.
interface sound_sequencer_if;
  logic       trigger;
  logic [1:0] sound_sel;
  logic       mute;
  logic [8:0] freq;
  logic       playSound;
  logic       busy;

  modport master (
    output trigger,
    output sound_sel,
    output mute,
    input  freq,
    input  playSound,
    input  busy
  );

  modport slave (
    input  trigger,
    input  sound_sel,
    input  mute,
    output freq,
    output playSound,
    output busy
  );
endinterface

// File: rtl/sound_sequencer.sv
// Turns one-cycle game-event triggers into timed note sequences from a small melody ROM.
// Each note is followed by a silent gap, except for the last note of a melody.
module sound_sequencer #(
  parameter int unsigned UNIT_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 250_000
) (
  input  logic              clk,
  input  logic              rst,
  sound_sequencer_if.slave  bus
);

  localparam int unsigned MaxCnt = (4 * UNIT_CYCLES > GAP_CYCLES) ? 4 * UNIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [1:0] SelNone  = 2'd0;
  localparam logic [1:0] SelEat   = 2'd1;
  localparam logic [1:0] SelOver  = 2'd2;
  localparam logic [1:0] SelStart = 2'd3;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  function automatic logic [8:0] note_freq(input logic [1:0] mel, input logic [1:0] idx);
    case ({mel, idx})
      {SelEat,   2'd0}: note_freq = 9'd262;
      {SelEat,   2'd1}: note_freq = 9'd392;
      {SelOver,  2'd0}: note_freq = 9'd392;
      {SelOver,  2'd1}: note_freq = 9'd311;
      {SelOver,  2'd2}: note_freq = 9'd262;
      {SelStart, 2'd0}: note_freq = 9'd262;
      {SelStart, 2'd1}: note_freq = 9'd330;
      {SelStart, 2'd2}: note_freq = 9'd392;
      {SelStart, 2'd3}: note_freq = 9'd440;
      default:          note_freq = 9'd0;
    endcase
  endfunction

  function automatic logic [2:0] note_len(input logic [1:0] mel, input logic [1:0] idx);
    case ({mel, idx})
      {SelOver,  2'd0}: note_len = 3'd2;
      {SelOver,  2'd1}: note_len = 3'd2;
      {SelOver,  2'd2}: note_len = 3'd4;
      {SelStart, 2'd3}: note_len = 3'd2;
      default:          note_len = 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] mel);
    case (mel)
      SelEat:   last_idx = 2'd1;
      SelOver:  last_idx = 2'd2;
      SelStart: last_idx = 2'd3;
      default:  last_idx = 2'd0;
    endcase
  endfunction

  // GAME_OVER outranks START, which outranks EAT.
  function automatic logic [1:0] prio(input logic [1:0] sel);
    case (sel)
      SelEat:   prio = 2'd1;
      SelStart: prio = 2'd2;
      SelOver:  prio = 2'd3;
      default:  prio = 2'd0;
    endcase
  endfunction

  function automatic logic [CntW-1:0] note_cycles(input logic [1:0] mel, input logic [1:0] idx);
    int unsigned prod;
    prod = 32'(note_len(mel, idx)) * UNIT_CYCLES;
    note_cycles = CntW'(prod);
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      mel_q, mel_d;
  logic [8:0]      freq_q, freq_d;
  logic            play_q, play_d;
  logic            busy_q, busy_d;

  logic            cnt_done;
  logic            ending;
  logic            accept;
  logic [1:0]      idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      mel_q   <= SelNone;
      freq_q  <= 9'd0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mel_q   <= mel_d;
      freq_q  <= freq_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mel_d    = mel_q;
    idx_next = idx_q + 2'd1;
    cnt_done = (cnt_q == CntW'(1));
    ending   = (state_q == StPlay) && cnt_done && (idx_q == last_idx(mel_q));
    // A melody on its final edge no longer guards against lower-priority triggers.
    accept   = bus.trigger && (bus.sound_sel != SelNone) &&
               ((state_q == StIdle) || ending || (prio(bus.sound_sel) >= prio(mel_q)));

    if (accept) begin
      state_d = StPlay;
      mel_d   = bus.sound_sel;
      idx_d   = 2'd0;
      cnt_d   = note_cycles(bus.sound_sel, 2'd0);
    end else begin
      case (state_q)
        StIdle: ;
        StPlay: begin
          if (!cnt_done) begin
            cnt_d = cnt_q - CntW'(1);
          end else if (idx_q == last_idx(mel_q)) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = CntW'(GAP_CYCLES);
          end
        end
        StGap: begin
          if (!cnt_done) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            state_d = StPlay;
            idx_d   = idx_next;
            cnt_d   = note_cycles(mel_q, idx_next);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are derived from the next state so they are registered alongside it.
  always_comb begin
    freq_d = 9'd0;
    play_d = 1'b0;
    busy_d = 1'b0;
    if (state_d != StIdle) begin
      freq_d = note_freq(mel_d, idx_d);
      busy_d = 1'b1;
      play_d = (state_d == StPlay) && !bus.mute;
    end
  end

  assign bus.freq      = freq_q;
  assign bus.playSound = play_q;
  assign bus.busy      = busy_q;

endmodule
